// File: rtl/data_ram_pipe.sv
// Byte-lane data memory with valid/ready request port, RD_LAT read pipeline and credit-managed response FIFO.
// Optional per-lane even parity storage and checking when DATA_RAM_PARITY_EN is defined.
`timescale 1ns/1ps
module data_ram_pipe #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int RD_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W/8-1:0]   req_sel,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF   = $clog2(NB);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int FD    = RD_LAT + 1;
  localparam int PW    = $clog2(FD);
  localparam int CW    = $clog2(FD + 1);
  localparam int NS    = (RD_LAT > 1) ? RD_LAT - 1 : 1;
  localparam logic [CW-1:0] FULL_CREDITS = CW'(FD);
  localparam logic [PW-1:0] LAST_SLOT    = PW'(FD - 1);

  // Handshake: a request moves on a posedge where req_valid && req_ready;
  // a response moves on a posedge where rsp_valid && rsp_ready.
  logic                  accept;
  logic                  pop;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  oor;
  logic [DATA_W-1:0]     rd_word;
  logic                  rd_bad;
  logic [DATA_W-1:0]     ent_data;
  logic                  ent_err;
  logic                  push;
  logic [DATA_W-1:0]     push_data;
  logic                  push_err;

  logic [DATA_W-1:0] mem [DEPTH];

  assign idx     = req_addr[DEPTH_LOG2+OFF-1:OFF];
  assign oor     = (req_addr >> (DEPTH_LOG2 + OFF)) != '0;
  assign rd_word = mem[idx];

  always_ff @(posedge clk) begin
    if (accept && req_we && !oor) begin
      for (int i = 0; i < NB; i++) begin
        if (req_sel[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

`ifdef DATA_RAM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (accept && req_we && !oor) begin
      for (int i = 0; i < NB; i++) begin
        if (req_sel[i]) par_mem[idx][i] <= ^req_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_bad = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if ((^rd_word[8*i +: 8]) != par_mem[idx][i]) rd_bad = 1'b1;
    end
  end
`else
  assign rd_bad = 1'b0;
`endif

  // Out-of-range and write responses carry zero data; only reads return the word.
  always_comb begin
    ent_data = '0;
    ent_err  = 1'b0;
    if (oor) begin
      ent_err = 1'b1;
    end else if (!req_we) begin
      ent_data = rd_word;
      ent_err  = rd_bad;
    end
  end

  generate
    if (RD_LAT == 1) begin : g_direct
      assign push      = accept;
      assign push_data = ent_data;
      assign push_err  = ent_err;
    end else begin : g_pipe
      logic [NS-1:0]     stg_v;
      logic [NS-1:0]     stg_e;
      logic [DATA_W-1:0] stg_d [NS];

      always_ff @(posedge clk) begin
        if (rst) begin
          stg_v <= '0;
        end else begin
          stg_v[0] <= accept;
          for (int i = 1; i < NS; i++) stg_v[i] <= stg_v[i-1];
        end
        stg_d[0] <= ent_data;
        stg_e[0] <= ent_err;
        for (int i = 1; i < NS; i++) begin
          stg_d[i] <= stg_d[i-1];
          stg_e[i] <= stg_e[i-1];
        end
      end

      assign push      = stg_v[NS-1];
      assign push_data = stg_d[NS-1];
      assign push_err  = stg_e[NS-1];
    end
  endgenerate

  logic [DATA_W-1:0] fifo_d [FD];
  logic [FD-1:0]     fifo_e;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     credits;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + 1'b1;
  endfunction

  // Credits cover pipeline plus FIFO, so admission alone keeps the FIFO from overflowing.
  assign req_ready = (credits < FULL_CREDITS) && !rst;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_rdata = rsp_valid ? fifo_d[rd_ptr] : '0;
  assign rsp_err   = rsp_valid && fifo_e[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_d[wr_ptr] <= push_data;
      fifo_e[wr_ptr] <= push_err;
    end
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      credits <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
      if (accept && !pop)      credits <= credits + 1'b1;
      else if (!accept && pop) credits <= credits - 1'b1;
    end
  end

endmodule

// File: tb/tb_data_ram_pipe.sv
// Directed bench for data_ram_pipe (default parameters, RD_LAT=2); parity case follows DATA_RAM_PARITY_EN.
`timescale 1ns/1ps
module tb_data_ram_pipe;

  localparam int RD_LAT = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_sel;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [32:0] exp_q[$];
  logic [32:0] rsp_q[$];
  int          acc_cyc[$];
  int          rsp_cyc[$];

  data_ram_pipe dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_sel(req_sel), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // monitor: observe handshakes mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (!rst && req_valid && req_ready) acc_cyc.push_back(cyc);
    if (!rst && rsp_valid && rsp_ready) begin
      rsp_q.push_back({rsp_err, rsp_rdata});
      rsp_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver
  task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                       input logic [31:0] wd);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_sel   = sel;
    req_wdata = wd;
    while (!req_ready && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) check("issue_timeout", 64'(req_ready), 64'd1);
    else begin
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  // scoreboard: wait for all expected responses, allow time for extras, compare in order
  task automatic drain(input string tag);
    int n;
    n = 0;
    while (rsp_q.size() < exp_q.size() && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_count"}, 64'(rsp_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && rsp_q.size() > 0)
      check(tag, 64'(rsp_q.pop_front()), 64'(exp_q.pop_front()));
    exp_q.delete();
    rsp_q.delete();
  endtask

  initial begin
    int          n_acc;
    logic [31:0] addr;
    logic [31:0] wd;

    rst = 1'b1; rsp_ready = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_sel = '0; req_wdata = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_rsp_err",   64'(rsp_err),   64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 64'(req_ready), 64'd1);
    rsp_ready = 1'b1;

    // 1: write then read, latency of the read
    acc_cyc.delete(); rsp_cyc.delete();
    issue(1'b1, 32'h10, 4'hF, 32'hDEADBEEF); exp_q.push_back({1'b0, 32'h0});
    issue(1'b0, 32'h10, 4'h0, 32'h0);        exp_q.push_back({1'b0, 32'hDEADBEEF});
    drain("wr_rd");
    check("rd_lat_count", 64'(rsp_cyc.size()), 64'd2);
    if (rsp_cyc.size() == 2 && acc_cyc.size() == 2)
      check("rd_latency", 64'(rsp_cyc[1] - acc_cyc[1]), 64'(RD_LAT));

    // 2: byte lanes and the empty-select write
    issue(1'b1, 32'h20, 4'hF, 32'h11223344); exp_q.push_back({1'b0, 32'h0});
    issue(1'b1, 32'h20, 4'h5, 32'hAABBCCDD); exp_q.push_back({1'b0, 32'h0});
    issue(1'b0, 32'h20, 4'h0, 32'h0);        exp_q.push_back({1'b0, 32'h11BB33DD});
    issue(1'b1, 32'h20, 4'h0, 32'hFFFFFFFF); exp_q.push_back({1'b0, 32'h0});
    issue(1'b0, 32'h20, 4'h0, 32'h0);        exp_q.push_back({1'b0, 32'h11BB33DD});
    drain("lanes");

    // 5a: out-of-range write must not alias onto word 4, out-of-range read errors
    issue(1'b1, 32'h1010, 4'hF, 32'h12345678); exp_q.push_back({1'b1, 32'h0});
    issue(1'b0, 32'h1000, 4'h0, 32'h0);        exp_q.push_back({1'b1, 32'h0});
    issue(1'b0, 32'h10,   4'h0, 32'h0);        exp_q.push_back({1'b0, 32'hDEADBEEF});
    drain("range");

    // 3: backpressure
    for (int i = 0; i < 4; i++) begin
      wd = 32'hA5000000 + 32'(i);
      issue(1'b1, 32'h100 + 32'(4 * i), 4'hF, wd);
      exp_q.push_back({1'b0, 32'h0});
    end
    drain("bp_fill");
    rsp_ready = 1'b0;
    n_acc = 0;
    req_valid = 1'b1; req_we = 1'b0; req_sel = 4'h0;
    for (int i = 0; i < 8; i++) begin
      logic will;
      req_addr = 32'h100 + 32'(4 * n_acc);
      will = req_ready;
      @(posedge clk); #1;
      if (will) n_acc++;
    end
    req_valid = 1'b0;
    check("bp_accepted", 64'(n_acc), 64'(RD_LAT + 1));
    check("bp_ready_low", 64'(req_ready), 64'd0);
    check("bp_head_valid", 64'(rsp_valid), 64'd1);
    check("bp_head_data", 64'(rsp_rdata), 64'h A5000000);
    repeat (3) @(posedge clk);
    #1;
    check("bp_head_hold", 64'(rsp_rdata), 64'hA5000000);
    check("bp_no_pop", 64'(rsp_q.size()), 64'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_ready_back", 64'(req_ready), 64'd1);
    issue(1'b0, 32'h10C, 4'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      wd = 32'hA5000000 + 32'(i);
      exp_q.push_back({1'b0, wd});
    end
    drain("bp_order");

    // 4: throughput
    for (int i = 0; i < 16; i++) begin
      wd = 32'hC0DE0000 + 32'(i);
      issue(1'b1, 32'h200 + 32'(4 * i), 4'hF, wd);
      exp_q.push_back({1'b0, 32'h0});
    end
    drain("thru_fill");
    acc_cyc.delete(); rsp_cyc.delete();
    req_valid = 1'b1; req_we = 1'b0; req_sel = 4'h0;
    for (int i = 0; i < 16; i++) begin
      req_addr = 32'h200 + 32'(4 * i);
      if (!req_ready) check("thru_ready", 64'(req_ready), 64'd1);
      @(posedge clk); #1;
      wd = 32'hC0DE0000 + 32'(i);
      exp_q.push_back({1'b0, wd});
    end
    req_valid = 1'b0;
    drain("thru_data");
    check("thru_rsp_count", 64'(rsp_cyc.size()), 64'd16);
    if (rsp_cyc.size() == 16) begin
      check("thru_consecutive", 64'(rsp_cyc[15] - rsp_cyc[0]), 64'd15);
      check("thru_first_lat", 64'(rsp_cyc[0] - acc_cyc[0]), 64'(RD_LAT));
    end

    // 5b: reset with three requests in flight
    rsp_ready = 1'b0;
    issue(1'b1, 32'h40, 4'hF, 32'h5A5A5A5A);
    issue(1'b0, 32'h10, 4'h0, 32'h0);
    issue(1'b0, 32'h20, 4'h0, 32'h0);
    check("inflight_full", 64'(req_ready), 64'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    #1;
    check("rst_mid_ready", 64'(req_ready), 64'd1);
    check("rst_mid_valid", 64'(rsp_valid), 64'd0);
    repeat (8) @(posedge clk);
    #1;
    check("rst_discard", 64'(rsp_q.size()), 64'd0);
    issue(1'b0, 32'h40, 4'h0, 32'h0); exp_q.push_back({1'b0, 32'h5A5A5A5A});
    drain("rst_persist");

    // 6: parity
`ifdef DATA_RAM_PARITY_EN
    dut.mem[8][9] = ~dut.mem[8][9];
    issue(1'b0, 32'h20, 4'h0, 32'h0); exp_q.push_back({1'b1, 32'h11BB31DD});
`else
    issue(1'b0, 32'h20, 4'h0, 32'h0); exp_q.push_back({1'b0, 32'h11BB33DD});
`endif
    drain("parity");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
